// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch-stage sequencer that owns the F-stage PC (pc_F).
// Each cycle pc_F holds, steps by 4, or loads a control-transfer target from
// the D-stage next-PC unit. It honours the hazard stall and the instruction
// memory ready handshake.
// If a redirect arrives while the delay-slot fetch is still outstanding, the
// target is parked and applied once that fetch completes.
// Optional feature macro: PC_ALIGN_CHK_EN enables the fetch address error
// flag (adel_f) and suppresses if_valid for bad fetch addresses.
// Next-PC opcodes normally come from macro.v. Local fallbacks are provided so
// this file stands on its own.
`timescale 1ns/1ps

`ifndef NPC_DEFAULT
`define NPC_DEFAULT 3'd0
`endif
`ifndef NPC_B
`define NPC_B 3'd1
`endif
`ifndef NPC_BN
`define NPC_BN 3'd2
`endif
`ifndef NPC_J
`define NPC_J 3'd3
`endif
`ifndef NPC_JR
`define NPC_JR 3'd4
`endif

module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        imem_ready,
   input  logic        d_valid,
   input  logic [2:0]  npc_op,
   input  logic        cmp_zero,
   input  logic [31:0] npc_tgt,
   output logic [31:0] pc_F,
   output logic        f_adv,
   output logic        if_valid,
   output logic        redir_pend,
   output logic        err_redir,
   output logic        adel_f
);

   // RUN: normal sequencing. PEND: a redirect is parked behind the delay slot.
   typedef enum logic [0:0] {
      RUN  = 1'b0,
      PEND = 1'b1
   } state_t;

   state_t      r_state;
   logic [31:0] r_pcF;
   logic [31:0] r_pendTgt;
   logic        r_redirPend;
   logic        r_errRedir;

   logic        w_branchHit;
   logic        w_take;
   logic [31:0] w_pcInc;
   logic        w_adel;

   // Decide whether the D-stage instruction redirects fetch. A stalled D
   // stage never redirects, so the branch is re-evaluated after the stall.
   always_comb begin
      w_branchHit = 1'b0;
      case (npc_op)
         `NPC_J:  w_branchHit = 1'b1;
         `NPC_JR: w_branchHit = 1'b1;
         `NPC_B:  w_branchHit = cmp_zero;
         `NPC_BN: w_branchHit = ~cmp_zero;
         default: w_branchHit = 1'b0;
      endcase
      w_take = d_valid & ~stall & w_branchHit;
   end

   // Sequential PC step. This is a plain 32-bit add that wraps past the top
   // of the address space.
   assign w_pcInc = r_pcF + 32'd4;

`ifdef PC_ALIGN_CHK_EN
   // Flag misaligned fetches and fetches outside the legal text window.
   // The PC still advances normally. Downstream logic sees a bubble plus
   // the flag.
   always_comb begin
      w_adel = (r_pcF[1:0] != 2'b00)
             | (r_pcF < 32'h0000_3000)
             | (r_pcF > 32'h0000_6FFC);
   end
`else
   assign w_adel = 1'b0;
`endif

   // Sequencer: reset wins, then stall, then the per-state redirect or step
   // rules. The delay slot at pc_F is always fetched before a redirect lands.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= RUN;
         r_pcF       <= RESET_PC;
         r_pendTgt   <= 32'h0000_0000;
         r_redirPend <= 1'b0;
         r_errRedir  <= 1'b0;
      end else if (!stall) begin
         case (r_state)
            RUN: begin
               if (w_take && imem_ready) begin
                  r_pcF <= npc_tgt;
               end else if (w_take) begin
                  r_pendTgt   <= npc_tgt;
                  r_state     <= PEND;
                  r_redirPend <= 1'b1;
               end else if (imem_ready) begin
                  r_pcF <= w_pcInc;
               end
            end
            PEND: begin
               if (w_take) begin
                  r_errRedir <= 1'b1;
               end
               if (imem_ready) begin
                  r_pcF       <= r_pendTgt;
                  r_state     <= RUN;
                  r_redirPend <= 1'b0;
               end
            end
            default: begin
               r_state     <= RUN;
               r_redirPend <= 1'b0;
            end
         endcase
      end
   end

   assign pc_F       = r_pcF;
   assign redir_pend = r_redirPend;
   assign err_redir  = r_errRedir;
   assign adel_f     = w_adel;
   assign f_adv      = ~stall;
   assign if_valid   = imem_ready & ~stall & ~w_adel;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: scoreboard bench for pc_fetch_ctrl.
// The stimulus side drives one cycle at a time and pushes the expected
// outputs from a behavioural model. A monitor pops and compares them mid-cycle.
`timescale 1ns/1ps

`ifndef NPC_DEFAULT
`define NPC_DEFAULT 3'd0
`endif
`ifndef NPC_B
`define NPC_B 3'd1
`endif
`ifndef NPC_BN
`define NPC_BN 3'd2
`endif
`ifndef NPC_J
`define NPC_J 3'd3
`endif
`ifndef NPC_JR
`define NPC_JR 3'd4
`endif

module tb_pc_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam logic [2:0]  OP_DEF = `NPC_DEFAULT;
   localparam logic [2:0]  OP_B   = `NPC_B;
   localparam logic [2:0]  OP_BN  = `NPC_BN;
   localparam logic [2:0]  OP_J   = `NPC_J;
   localparam logic [2:0]  OP_JR  = `NPC_JR;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        imem_ready;
   logic        d_valid;
   logic [2:0]  npc_op;
   logic        cmp_zero;
   logic [31:0] npc_tgt;
   logic [31:0] pc_F;
   logic        f_adv;
   logic        if_valid;
   logic        redir_pend;
   logic        err_redir;
   logic        adel_f;

   typedef struct {
      logic [31:0] pc;
      logic        fAdv;
      logic        ifValid;
      logic        redirPend;
      logic        errRedir;
      logic        adel;
   } expect_t;

   expect_t expQ[$];

   int checks = 0;
   int failures = 0;

   logic [31:0] mPc;
   logic        mPend;
   logic [31:0] mPendTgt;
   logic        mErr;

   pc_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .imem_ready (imem_ready),
      .d_valid    (d_valid),
      .npc_op     (npc_op),
      .cmp_zero   (cmp_zero),
      .npc_tgt    (npc_tgt),
      .pc_F       (pc_F),
      .f_adv      (f_adv),
      .if_valid   (if_valid),
      .redir_pend (redir_pend),
      .err_redir  (err_redir),
      .adel_f     (adel_f)
   );

   // Free-running clock with a 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Fetch address error rule, written directly from the address window.
   function automatic logic modelAdel(input logic [31:0] pc);
`ifdef PC_ALIGN_CHK_EN
      return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
`else
      return 1'b0;
`endif
   endfunction

   // Compare one DUT value against its expected value and count the result.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs and push the expected outputs for this cycle.
   // Then advance the model state and wait until just after the clock edge.
   task automatic applyStimulus(input logic rst, input logic stl, input logic rdy,
                                input logic dv, input logic [2:0] op,
                                input logic cz, input logic [31:0] tgt);
      expect_t e;
      logic    redirect;
      reset      = rst;
      stall      = stl;
      imem_ready = rdy;
      d_valid    = dv;
      npc_op     = op;
      cmp_zero   = cz;
      npc_tgt    = tgt;

      e.pc        = mPc;
      e.fAdv      = !stl;
      e.adel      = modelAdel(mPc);
      e.ifValid   = rdy && !stl && !e.adel;
      e.redirPend = mPend;
      e.errRedir  = mErr;
      expQ.push_back(e);

      redirect = dv && !stl &&
                 (op == OP_J || op == OP_JR || (op == OP_B && cz) || (op == OP_BN && !cz));
      if (rst) begin
         mPc = RST_PC; mPend = 1'b0; mPendTgt = 32'h0; mErr = 1'b0;
      end else if (!stl) begin
         if (mPend) begin
            if (redirect) mErr = 1'b1;
            if (rdy) begin
               mPc = mPendTgt;
               mPend = 1'b0;
            end
         end else if (redirect) begin
            if (rdy) mPc = tgt;
            else begin
               mPend = 1'b1;
               mPendTgt = tgt;
            end
         end else if (rdy) begin
            mPc = mPc + 32'd4;
         end
      end

      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the expected outputs for the current cycle and compares
   // them at mid-cycle, well away from the active edge.
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         expect_t e;
         e = expQ.pop_front();
         checkOutput("pc_F", pc_F, e.pc);
         checkOutput("f_adv", {31'b0, f_adv}, {31'b0, e.fAdv});
         checkOutput("if_valid", {31'b0, if_valid}, {31'b0, e.ifValid});
         checkOutput("redir_pend", {31'b0, redir_pend}, {31'b0, e.redirPend});
         checkOutput("err_redir", {31'b0, err_redir}, {31'b0, e.errRedir});
         checkOutput("adel_f", {31'b0, adel_f}, {31'b0, e.adel});
      end
   end

   // Watchdog so the run always ends even if the stimulus stalls.
   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios first, then a long randomized run.
   initial begin
      logic [31:0] rTgt;
      reset = 1'b1; stall = 1'b0; imem_ready = 1'b0; d_valid = 1'b0;
      npc_op = OP_DEF; cmp_zero = 1'b0; npc_tgt = 32'h0;
      @(posedge clk);
      #1;
      mPc = RST_PC; mPend = 1'b0; mPendTgt = 32'h0; mErr = 1'b0;

      // Reset sequencing followed by three sequential fetches.
      applyStimulus(1, 0, 0, 0, OP_DEF, 0, 32'h0);
      checkOutput("reset_pc", pc_F, 32'h3000);
      applyStimulus(0, 0, 1, 0, OP_DEF, 0, 32'h0);
      applyStimulus(0, 0, 1, 0, OP_DEF, 0, 32'h0);
      applyStimulus(0, 0, 1, 0, OP_DEF, 0, 32'h0);
      checkOutput("seq_pc", pc_F, 32'h300C);

      // Branch taken and branch not taken.
      applyStimulus(0, 0, 1, 0, OP_DEF, 0, 32'h0);
      applyStimulus(0, 0, 1, 1, OP_B, 1, 32'h3040);
      checkOutput("b_taken", pc_F, 32'h3040);
      applyStimulus(0, 0, 1, 1, OP_B, 0, 32'h3080);
      checkOutput("b_not_taken", pc_F, 32'h3044);

      // A jump held off by a two-cycle stall, then released.
      applyStimulus(0, 1, 1, 1, OP_J, 0, 32'h3100);
      applyStimulus(0, 1, 1, 1, OP_J, 0, 32'h3100);
      checkOutput("stall_hold", pc_F, 32'h3044);
      applyStimulus(0, 0, 1, 1, OP_J, 0, 32'h3100);
      checkOutput("stall_release", pc_F, 32'h3100);

      // A redirect parked behind an outstanding delay-slot fetch.
      applyStimulus(0, 0, 1, 0, OP_DEF, 0, 32'h0);
      applyStimulus(0, 0, 0, 1, OP_JR, 0, 32'h3200);
      applyStimulus(0, 0, 0, 0, OP_DEF, 0, 32'h0);
      applyStimulus(0, 0, 0, 0, OP_DEF, 0, 32'h0);
      checkOutput("pend_flag", {31'b0, redir_pend}, 32'h1);
      checkOutput("pend_hold", pc_F, 32'h3104);
      applyStimulus(0, 0, 1, 0, OP_DEF, 0, 32'h0);
      checkOutput("pend_apply", pc_F, 32'h3200);
      checkOutput("pend_clear", {31'b0, redir_pend}, 32'h0);

      // A second redirect while one is already parked.
      applyStimulus(0, 0, 0, 1, OP_JR, 0, 32'h3240);
      applyStimulus(0, 0, 0, 1, OP_JR, 0, 32'h3300);
      applyStimulus(0, 0, 1, 0, OP_DEF, 0, 32'h0);
      checkOutput("double_tgt", pc_F, 32'h3240);
      checkOutput("double_err", {31'b0, err_redir}, 32'h1);
      applyStimulus(0, 0, 1, 0, OP_DEF, 0, 32'h0);
      checkOutput("err_sticky", {31'b0, err_redir}, 32'h1);
      applyStimulus(1, 0, 1, 0, OP_DEF, 0, 32'h0);
      checkOutput("err_reset", {31'b0, err_redir}, 32'h0);

      // Misaligned and below-window fetch addresses.
      applyStimulus(0, 0, 1, 1, OP_JR, 0, 32'h3002);
      checkOutput("adel_misalign", pc_F, 32'h3002);
`ifdef PC_ALIGN_CHK_EN
      checkOutput("adel_flag_a", {31'b0, adel_f}, 32'h1);
`else
      checkOutput("adel_flag_a", {31'b0, adel_f}, 32'h0);
`endif
      applyStimulus(0, 0, 1, 0, OP_DEF, 0, 32'h0);
      checkOutput("adel_advance", pc_F, 32'h3006);
      applyStimulus(0, 0, 1, 1, OP_JR, 0, 32'h2FFC);
`ifdef PC_ALIGN_CHK_EN
      checkOutput("adel_flag_b", {31'b0, adel_f}, 32'h1);
`else
      checkOutput("adel_flag_b", {31'b0, adel_f}, 32'h0);
`endif

      // Wrap past the top of the address space.
      applyStimulus(0, 0, 1, 1, OP_J, 0, 32'hFFFF_FFFC);
      applyStimulus(0, 0, 1, 0, OP_DEF, 0, 32'h0);
      checkOutput("pc_wrap", pc_F, 32'h0);

      // Randomized traffic, including illegal opcodes and occasional resets.
      applyStimulus(1, 0, 0, 0, OP_DEF, 0, 32'h0);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) rTgt = $urandom();
         else rTgt = $urandom_range(32'h3000, 32'h6FFC) & 32'hFFFF_FFFC;
         applyStimulus($urandom_range(0, 199) == 0,
                       $urandom_range(0, 3) == 0,
                       $urandom_range(0, 9) < 7,
                       $urandom_range(0, 4) != 0,
                       3'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)),
                       rTgt);
      end

      // Allow the monitor to drain its queue.
      for (int i = 0; i < 4 && expQ.size() > 0; i++) @(posedge clk);
      checkOutput("queue_drained", expQ.size(), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
